// File: rtl/instruction_loader.sv
// instruction_loader: assembles MSB-first serial bytes from the debug UART
// into instruction words and issues single-cycle write strobes toward the
// fetch stage's instruction memory. A load ends on the halt word, on memory
// overflow, or on an inter-byte timeout within a partial word.
module instruction_loader #(
   parameter int unsigned WORD_SIZE_IN_BYTES = 4,
   parameter int unsigned MEM_SIZE_IN_WORDS  = 64,
   parameter logic [WORD_SIZE_IN_BYTES*8-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF,
   parameter int unsigned TIMEOUT_CYCLES     = 1000000,
   localparam int unsigned BUS_SIZE = WORD_SIZE_IN_BYTES * 8,
   localparam int unsigned CNT_W    = $clog2(MEM_SIZE_IN_WORDS) + 1
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start_load,
   input  logic                i_rx_valid,
   input  logic [7:0]          i_rx_data,
   input  logic                i_mem_full,
   output logic                o_write_mem,
   output logic [BUS_SIZE-1:0] o_instruction,
   output logic                o_busy,
   output logic                o_load_done,
   output logic                o_error,
   output logic [CNT_W-1:0]    o_word_count
);

   localparam int unsigned IDX_W = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_SIZE_IN_BYTES - 1);
   localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_SIZE_IN_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      RECEIVE,
      WRITE,
      DONE,
      ERROR
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [BUS_SIZE-1:0] shift_q, shift_d;
   logic [BUS_SIZE-1:0] instr_q, instr_d;
   logic [TO_W-1:0]     tcnt_q, tcnt_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [BUS_SIZE-1:0] shifted;

   // New byte enters at the LSBs so the first byte ends up as the MSB.
   assign shifted = BUS_SIZE'({shift_q, i_rx_data});

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         shift_q <= '0;
         instr_q <= '0;
         tcnt_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         instr_q <= instr_d;
         tcnt_q  <= tcnt_d;
         count_q <= count_d;
      end
   end

   // Next-state, datapath updates and state-decoded outputs.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      instr_d     = instr_q;
      tcnt_d      = tcnt_q;
      count_d     = count_q;
      o_write_mem = 1'b0;
      o_busy      = 1'b0;
      o_load_done = 1'b0;
      o_error     = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start_load) begin
               state_d = RECEIVE;
               idx_d   = '0;
               shift_d = '0;
               tcnt_d  = '0;
               count_d = '0;
            end
         end

         RECEIVE: begin
            o_busy = 1'b1;
            if (i_rx_valid) begin
               shift_d = shifted;
               tcnt_d  = '0;
               if (idx_q == IDX_LAST) begin
                  instr_d = shifted;
                  idx_d   = '0;
                  state_d = WRITE;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else if (idx_q != '0) begin
               if (tcnt_q == TO_LAST) begin
                  state_d = ERROR;
                  idx_d   = '0;
                  tcnt_d  = '0;
               end else begin
                  tcnt_d = tcnt_q + TO_ONE;
               end
            end
         end

         WRITE: begin
            o_busy  = 1'b1;
            idx_d   = '0;
            shift_d = '0;
            tcnt_d  = '0;
            if (i_mem_full) begin
               state_d = ERROR;
            end else begin
               o_write_mem = 1'b1;
               if (count_q != CNT_MAX) begin
                  count_d = count_q + CNT_ONE;
               end
               if (instr_q == HALT_INSTRUCTION) begin
                  state_d = DONE;
               end else begin
                  state_d = RECEIVE;
                  // A byte arriving during the strobe starts the next word.
                  if (i_rx_valid) begin
                     idx_d   = IDX_ONE;
                     shift_d = BUS_SIZE'(i_rx_data);
                  end
               end
            end
         end

         DONE: begin
            o_load_done = 1'b1;
            if (i_start_load) begin
               state_d = RECEIVE;
               idx_d   = '0;
               shift_d = '0;
               tcnt_d  = '0;
               count_d = '0;
            end
         end

         ERROR: begin
            o_error = 1'b1;
            if (i_start_load) begin
               state_d = RECEIVE;
               idx_d   = '0;
               shift_d = '0;
               tcnt_d  = '0;
               count_d = '0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_instruction = instr_q;
   assign o_word_count  = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader (TIMEOUT_CYCLES = 16).
module tb_instruction_loader;

   logic        i_clk;
   logic        i_reset;
   logic        i_start_load;
   logic        i_rx_valid;
   logic [7:0]  i_rx_data;
   logic        i_mem_full;
   logic        o_write_mem;
   logic [31:0] o_instruction;
   logic        o_busy;
   logic        o_load_done;
   logic        o_error;
   logic [6:0]  o_word_count;

   int checks;
   int errors;

   instruction_loader #(
      .WORD_SIZE_IN_BYTES(4),
      .MEM_SIZE_IN_WORDS (64),
      .HALT_INSTRUCTION  (32'hFFFF_FFFF),
      .TIMEOUT_CYCLES    (16)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_start_load (i_start_load),
      .i_rx_valid   (i_rx_valid),
      .i_rx_data    (i_rx_data),
      .i_mem_full   (i_mem_full),
      .o_write_mem  (o_write_mem),
      .o_instruction(o_instruction),
      .o_busy       (o_busy),
      .o_load_done  (o_load_done),
      .o_error      (o_error),
      .o_word_count (o_word_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   // advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      tick();
      tick();
      i_reset = 1'b0;
   endtask

   task automatic start_load();
      i_start_load = 1'b1;
      tick();
      i_start_load = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      tick();
      i_rx_valid = 1'b0;
      i_rx_data  = 8'h00;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({o_write_mem, o_busy, o_load_done, o_error} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b required 0000", {o_write_mem, o_busy, o_load_done, o_error});
      end
      checks++;
      if (o_word_count !== 7'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d required 0", o_word_count);
      end
      checks++;
      if (o_instruction !== 32'h0) begin
         errors++;
         $display("FAIL reset_instr: got %h required 00000000", o_instruction);
      end
      // rx bytes in IDLE are ignored
      for (int i = 0; i < 4; i++) begin
         send_byte(8'hFF);
         checks++;
         if (o_write_mem !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got write=%b busy=%b required 0 0", o_write_mem, o_busy);
         end
      end
   endtask

   task automatic test_halt_load();
      do_reset();
      start_load();
      checks++;
      if (o_busy !== 1'b1) begin
         errors++;
         $display("FAIL start_busy: got %b required 1", o_busy);
      end
      send_byte(8'h24); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
      checks++;
      if (o_write_mem !== 1'b1 || o_instruction !== 32'h2401_0005) begin
         errors++;
         $display("FAIL halt_word0: got write=%b instr=%h required 1 24010005", o_write_mem, o_instruction);
      end
      tick();
      checks++;
      if (o_write_mem !== 1'b0) begin
         errors++;
         $display("FAIL halt_strobe_len: got %b required 0", o_write_mem);
      end
      send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
      checks++;
      if (o_write_mem !== 1'b1 || o_instruction !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL halt_word1: got write=%b instr=%h required 1 ffffffff", o_write_mem, o_instruction);
      end
      tick();
      checks++;
      if (o_load_done !== 1'b1 || o_busy !== 1'b0 || o_word_count !== 7'd2 || o_write_mem !== 1'b0) begin
         errors++;
         $display("FAIL halt_done: got done=%b busy=%b count=%0d write=%b required 1 0 2 0",
                  o_load_done, o_busy, o_word_count, o_write_mem);
      end
      // bytes in DONE are ignored and the count holds
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      checks++;
      if (o_load_done !== 1'b1 || o_write_mem !== 1'b0 || o_word_count !== 7'd2) begin
         errors++;
         $display("FAIL done_ignore: got done=%b write=%b count=%0d required 1 0 2",
                  o_load_done, o_write_mem, o_word_count);
      end
   endtask

   task automatic test_single_word();
      do_reset();
      start_load();
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
      checks++;
      if (o_write_mem !== 1'b0) begin
         errors++;
         $display("FAIL single_early: got %b required 0", o_write_mem);
      end
      send_byte(8'h78);
      checks++;
      if (o_write_mem !== 1'b1 || o_instruction !== 32'h1234_5678) begin
         errors++;
         $display("FAIL single_word: got write=%b instr=%h required 1 12345678", o_write_mem, o_instruction);
      end
      tick();
      checks++;
      if (o_write_mem !== 1'b0 || o_busy !== 1'b1 || o_word_count !== 7'd1 || o_instruction !== 32'h1234_5678) begin
         errors++;
         $display("FAIL single_after: got write=%b busy=%b count=%0d instr=%h required 0 1 1 12345678",
                  o_write_mem, o_busy, o_word_count, o_instruction);
      end
   endtask

   task automatic test_mem_full();
      do_reset();
      start_load();
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      tick();
      send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
      i_mem_full = 1'b1;
      send_byte(8'hA4);
      checks++;
      if (o_write_mem !== 1'b0) begin
         errors++;
         $display("FAIL full_strobe: got %b required 0", o_write_mem);
      end
      tick();
      i_mem_full = 1'b0;
      checks++;
      if (o_error !== 1'b1 || o_busy !== 1'b0 || o_word_count !== 7'd1) begin
         errors++;
         $display("FAIL full_error: got error=%b busy=%b count=%0d required 1 0 1",
                  o_error, o_busy, o_word_count);
      end
      // simultaneous start and byte: load starts, byte discarded
      i_rx_valid = 1'b1;
      i_rx_data  = 8'h99;
      start_load();
      i_rx_valid = 1'b0;
      checks++;
      if (o_busy !== 1'b1 || o_error !== 1'b0 || o_word_count !== 7'd0) begin
         errors++;
         $display("FAIL full_restart: got busy=%b error=%b count=%0d required 1 0 0",
                  o_busy, o_error, o_word_count);
      end
      send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
      checks++;
      if (o_write_mem !== 1'b1 || o_instruction !== 32'h1020_3040) begin
         errors++;
         $display("FAIL restart_word: got write=%b instr=%h required 1 10203040", o_write_mem, o_instruction);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      start_load();
      for (int i = 0; i < 100; i++) tick();
      checks++;
      if (o_error !== 1'b0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL idle_no_timeout: got error=%b busy=%b required 0 1", o_error, o_busy);
      end
      send_byte(8'h55); send_byte(8'h66);
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if (o_error !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: got %b required 0", o_error);
      end
      tick();
      checks++;
      if (o_error !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_fire: got error=%b busy=%b required 1 0", o_error, o_busy);
      end
   endtask

   task automatic test_reset_midword();
      do_reset();
      start_load();
      send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      checks++;
      if ({o_write_mem, o_busy, o_load_done, o_error} !== 4'b0000 || o_word_count !== 7'd0 || o_instruction !== 32'h0) begin
         errors++;
         $display("FAIL midword_reset: got flags=%b count=%0d instr=%h required 0000 0 00000000",
                  {o_write_mem, o_busy, o_load_done, o_error}, o_word_count, o_instruction);
      end
      send_byte(8'hC4);
      checks++;
      if (o_write_mem !== 1'b0) begin
         errors++;
         $display("FAIL midword_nostrobe: got %b required 0", o_write_mem);
      end
      send_byte(8'hC5); send_byte(8'hC6); send_byte(8'hC7); send_byte(8'hC8);
      checks++;
      if (o_write_mem !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_bytes: got write=%b busy=%b required 0 0", o_write_mem, o_busy);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      start_load();
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      checks++;
      if (o_write_mem !== 1'b1 || o_instruction !== 32'hAABB_CCDD) begin
         errors++;
         $display("FAIL b2b_word0: got write=%b instr=%h required 1 aabbccdd", o_write_mem, o_instruction);
      end
      send_byte(8'hEE);
      send_byte(8'hFF); send_byte(8'h00);
      checks++;
      if (o_write_mem !== 1'b0) begin
         errors++;
         $display("FAIL b2b_early: got %b required 0", o_write_mem);
      end
      send_byte(8'h11);
      checks++;
      if (o_write_mem !== 1'b1 || o_instruction !== 32'hEEFF_0011) begin
         errors++;
         $display("FAIL b2b_word1: got write=%b instr=%h required 1 eeff0011", o_write_mem, o_instruction);
      end
      tick();
      checks++;
      if (o_word_count !== 7'd2 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_count: got count=%0d busy=%b required 2 1", o_word_count, o_busy);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      i_reset      = 1'b0;
      i_start_load = 1'b0;
      i_rx_valid   = 1'b0;
      i_rx_data    = 8'h00;
      i_mem_full   = 1'b0;
      #1;
      test_reset();
      test_halt_load();
      test_single_word();
      test_mem_full();
      test_timeout();
      test_reset_midword();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
